alu_mc: RTL and testbench

//  Multi-cycle, parametrised picoMIPS ALU with a valid/ready handshake on both sides.
//  ADD/SUB/NOP complete in 1 cycle; signed fixed-point MUL runs iteratively, one partial product per cycle.

---
 rtl/alu_mc.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_mc.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle picoMIPS ALU with valid/ready handshakes on issue and writeback.
// ADD/SUB/NOP finish in one cycle. Signed fixed-point MUL runs one partial product per cycle.
// Optional build macro: ALU_SAT_EN. When defined, an overflowing result saturates to the
// most positive or most negative value. When undefined, results wrap around.
// Function codes normally come from alucodes.sv. The fallbacks below apply only when it is absent.

`ifndef RNOP
`define RNOP 3'b000
`endif
`ifndef RADD
`define RADD 3'b010
`endif
`ifndef RSUB
`define RSUB 3'b011
`endif
`ifndef RMUL
`define RMUL 3'b100
`endif

module alu_mc #(
    parameter int N    = 8,
    parameter int FRAC = N - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [2:0]   alu_func,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [3:0]   flags
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_next;

    logic           accept;
    logic           is_mul;
    logic           last_iter;

    // Iterative multiplier state.
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] acc_next;
    logic [2*N-1:0] p_sh;

    // Single-cycle path.
    logic [N:0]     sum;
    logic [N:0]     dif;
    logic [N-1:0]   fast_res;
    logic           fast_v;
    logic           fast_c;

    // Multiply result extraction.
    logic [N-1:0]   mul_res;
    logic [N:0]     mul_hi;
    logic           mul_v;

    // Final result, selected from whichever path is completing.
    logic [N-1:0]   res_raw;
    logic [N-1:0]   res;
    logic           res_v;
    logic           res_c;
    logic [3:0]     res_flags;

`ifdef ALU_SAT_EN
    logic           fast_neg;
    logic           mul_neg;
    logic           res_neg;
`endif

    assign accept    = in_valid & in_ready;
    assign is_mul    = (alu_func == `RMUL);
    assign last_iter = (cnt == CW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE accepts the next operation in the same cycle that its result is consumed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_mul ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_next = is_mul ? BUSY : DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        in_ready  = !reset && ((state == IDLE) || ((state == DONE) && out_ready));
        out_valid = (state == DONE);
    end

    // Single-cycle ADD/SUB/NOP evaluated directly on the presented operands.
    always_comb begin
        sum      = {1'b0, in1} + {1'b0, in2};
        dif      = {1'b0, in1} - {1'b0, in2};
        fast_res = in1;
        fast_v   = 1'b0;
        fast_c   = 1'b0;
        case (alu_func)
            `RADD: begin
                fast_res = sum[N-1:0];
                fast_c   = sum[N];
                fast_v   = (in1[N-1] == in2[N-1]) && (sum[N-1] != in1[N-1]);
            end
            `RSUB: begin
                fast_res = dif[N-1:0];
                fast_c   = dif[N];
                fast_v   = (in1[N-1] != in2[N-1]) && (dif[N-1] != in1[N-1]);
            end
            default: begin
                fast_res = in1;
            end
        endcase
`ifdef ALU_SAT_EN
        fast_neg = in1[N-1];
`endif
    end

    // One signed shift-add step. The multiplier sign bit has negative weight, so the last step subtracts.
    always_comb begin
        pp       = mplier[0] ? mcand : '0;
        acc_next = last_iter ? (acc - pp) : (acc + pp);
        p_sh     = $signed(acc_next) >>> FRAC;
        mul_res  = p_sh[N-1:0];
        mul_hi   = p_sh[2*N-1:N-1];
        mul_v    = (mul_hi != '0) && (mul_hi != '1);
`ifdef ALU_SAT_EN
        mul_neg  = acc_next[2*N-1];
`endif
    end

    // Select the completing path, saturate if enabled, and derive the flags from the final value.
    always_comb begin
        if (state == BUSY) begin
            res_raw = mul_res;
            res_v   = mul_v;
            res_c   = 1'b0;
        end else begin
            res_raw = fast_res;
            res_v   = fast_v;
            res_c   = fast_c;
        end
        res = res_raw;
`ifdef ALU_SAT_EN
        res_neg = (state == BUSY) ? mul_neg : fast_neg;
        if (res_v) begin
            res = res_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
        res_flags = {res[N-1], ~|res, res_c, res_v};
    end

    // Datapath registers: operand capture at accept, multiply iterations, result writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= '0;
            flags  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept) begin
            if (is_mul) begin
                acc    <= '0;
                mcand  <= {{N{in1[N-1]}}, in1};
                mplier <= in2;
                cnt    <= CW'(N);
            end else begin
                out   <= res;
                flags <= res_flags;
            end
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (last_iter) begin
                out   <= res;
                flags <= res_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random checks of alu_mc (N=8, FRAC=7) with a scoreboard of expected results.

`ifndef RNOP
`define RNOP 3'b000
`endif
`ifndef RADD
`define RADD 3'b010
`endif
`ifndef RSUB
`define RSUB 3'b011
`endif
`ifndef RMUL
`define RMUL 3'b100
`endif

module tb_alu_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [2:0] alu_func;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [3:0] flags;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    typedef struct {
        logic [7:0] o;
        logic [3:0] f;
        int         lat;
        string      tag;
    } exp_t;

    exp_t sb[$];

    alu_mc #(
        .N    (8),
        .FRAC (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .alu_func  (alu_func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: integer arithmetic, returns {flags, out}.
    function automatic logic [11:0] model(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        int sa, sb2, r;
        logic [7:0] o;
        logic v, c;
        sa  = int'($signed(a));
        sb2 = int'($signed(b));
        r   = sa;
        v   = 1'b0;
        c   = 1'b0;
        case (f)
            `RADD: begin
                r = sa + sb2;
                c = (int'(a) + int'(b)) > 255;
            end
            `RSUB: begin
                r = sa - sb2;
                c = (a < b);
            end
            `RMUL: r = (sa * sb2) >>> 7;
            default: r = sa;
        endcase
        v = (r > 127) || (r < -128);
        o = r[7:0];
`ifdef ALU_SAT_EN
        if (v) o = (r < 0) ? 8'h80 : 8'h7F;
`endif
        return {o[7], (o == 8'h00), c, v, o};
    endfunction

    task automatic send(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b, input logic push,
                        input logic [7:0] eo, input logic [3:0] ef, input int lat, input string tag);
        int w;
        exp_t e;
        w = 0;
        in_valid = 1'b1;
        alu_func = f;
        in1      = a;
        in2      = b;
        #1;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_in_ready"}, 16'(in_ready), 16'h1);
        if (push) begin
            e.o = eo; e.f = ef; e.lat = lat; e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in1      = 8'($urandom);
        in2      = 8'($urandom);
        alu_func = 3'($urandom);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 required=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_out"}, 16'(out), 16'(e.o));
            check({e.tag, "_flags"}, 16'(flags), 16'(e.f));
        end
    endtask

    task automatic recv(input int stall);
        int waited;
        logic seen, rdy_busy;
        int exp_lat;
        out_ready = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        seen = out_valid;
        rdy_busy = 1'b0;
        waited = 0;
        while (!seen && waited < 40) begin
            if (in_ready) rdy_busy = 1'b1;
            @(posedge clk); #1;
            waited++;
            seen = out_valid;
        end
        checks++;
        assert (seen) else begin
            failures++;
            $error("FAIL out_valid_timeout observed=0 required=1");
        end
        if (seen) begin
            exp_lat = (sb.size() > 0) ? sb[0].lat : 0;
            if (stall == 0) begin
                check("latency", 16'(cyc - acc_cyc + 1), 16'(exp_lat));
            end
            if (exp_lat > 1) begin
                check("in_ready_busy", 16'(rdy_busy), 16'h0);
            end
            pop_check();
            @(posedge clk); #1;
            check("out_valid_cleared", 16'(out_valid), 16'h0);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  eo;
        logic [3:0]  ef;
        logic [11:0] m;
        logic        stayed;
        logic [2:0]  f;
        logic [7:0]  a, b;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        alu_func  = `RNOP;

        // Reset state
        @(posedge clk); #1;
        check("reset_in_ready", 16'(in_ready), 16'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out", 16'(out), 16'h0);
        check("rst_flags", 16'(flags), 16'h0);
        check("rst_in_ready", 16'(in_ready), 16'h1);

        // ADD with signed overflow
`ifdef ALU_SAT_EN
        eo = 8'h7F; ef = 4'b0001;
`else
        eo = 8'h90; ef = 4'b1001;
`endif
        send(`RADD, 8'h70, 8'h20, 1'b1, eo, ef, 1, "add_ovf");
        recv(0);

        // SUB with borrow, then SUB with overflow
        send(`RSUB, 8'h10, 8'h20, 1'b1, 8'hF0, 4'b1010, 1, "sub_borrow");
        recv(0);
`ifdef ALU_SAT_EN
        eo = 8'h80; ef = 4'b1001;
`else
        eo = 8'h7F; ef = 4'b0001;
`endif
        send(`RSUB, 8'h80, 8'h01, 1'b1, eo, ef, 1, "sub_ovf");
        recv(0);

        // NOP and undefined code pass in1 through
        send(`RNOP, 8'h5A, 8'h33, 1'b1, 8'h5A, 4'b0000, 1, "nop");
        recv(0);
        send(3'b111, 8'h00, 8'hC3, 1'b1, 8'h00, 4'b0100, 1, "undef");
        recv(0);

        // MUL cases
        send(`RMUL, 8'h40, 8'h40, 1'b1, 8'h20, 4'b0000, 9, "mul_half");
        recv(0);
`ifdef ALU_SAT_EN
        eo = 8'h7F; ef = 4'b0001;
`else
        eo = 8'h80; ef = 4'b1001;
`endif
        send(`RMUL, 8'h80, 8'h80, 1'b1, eo, ef, 9, "mul_m1m1");
        recv(0);
        send(`RMUL, 8'hC0, 8'h40, 1'b1, 8'hE0, 4'b1000, 9, "mul_neg");
        recv(0);

        // Backpressure, then back-to-back accept while consuming
        send(`RADD, 8'h12, 8'h34, 1'b1, 8'h46, 4'b0000, 1, "bp_hold");
        out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_out_valid", 16'(out_valid), 16'h1);
            check("bp_out", 16'(out), 16'h46);
            check("bp_flags", 16'(flags), 16'h0);
            check("bp_in_ready", 16'(in_ready), 16'h0);
        end
        in_valid  = 1'b1;
        alu_func  = `RADD;
        in1       = 8'h01;
        in2       = 8'hFF;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 16'(in_ready), 16'h1);
        pop_check();
        begin
            exp_t e;
            e.o = 8'h00; e.f = 4'b0110; e.lat = 1; e.tag = "b2b_add";
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_out_valid", 16'(out_valid), 16'h1);
        pop_check();
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_consumed", 16'(out_valid), 16'h0);

        // Reset three cycles into a MUL aborts it
        send(`RNOP, 8'h5A, 8'h00, 1'b1, 8'h5A, 4'b0000, 1, "pre_abort");
        recv(0);
        send(`RMUL, 8'h40, 8'h40, 1'b0, 8'h00, 4'b0000, 9, "mul_abort");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_in_ready_rst", 16'(in_ready), 16'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_out_valid", 16'(out_valid), 16'h0);
        check("abort_out", 16'(out), 16'h0);
        check("abort_flags", 16'(flags), 16'h0);
        check("abort_in_ready", 16'(in_ready), 16'h1);
        stayed = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) stayed = 1'b0;
        end
        check("abort_no_result", 16'(stayed), 16'h1);
        send(`RADD, 8'h03, 8'h04, 1'b1, 8'h07, 4'b0000, 1, "add_after_abort");
        recv(0);

        // Random operations against the reference model
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 4))
                0: f = `RADD;
                1: f = `RSUB;
                2: f = `RMUL;
                3: f = `RNOP;
                default: f = 3'b111;
            endcase
            a = 8'($urandom);
            b = 8'($urandom);
            m = model(f, a, b);
            send(f, a, b, 1'b1, m[7:0], m[11:8], (f == `RMUL) ? 9 : 1, $sformatf("rand%0d", i));
            recv($urandom_range(0, 2));
        end

        check("sb_drained", 16'(sb.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
